// File: rtl/nes_oam_dma.sv
// nes_oam_dma: sprite OAM DMA engine sitting behind the CPU core's write port.
// Snoops CPU writes to TRIGGER_ADDR. On a hit it halts the CPU, takes the bus,
// and copies 256 bytes from page {cpu_wdata,00..FF} to OAM_DATA_ADDR as
// alternating get (read, even) / put (write, odd) CPU cycles.
// All sequencing advances only on cpu_cycle_en; outputs hold between strobes.
//
// Optional build macro: NES_OAM_DMA_STATS_EN adds dma_count, a modulo-256
// count of completed transfers.
//
// Ports:
//   clock, reset      master clock, synchronous active-high reset
//   cpu_cycle_en      one-clock strobe ending each CPU cycle
//   cpu_addr/wdata/rw snooped CPU bus (rw: 1 = read, 0 = write)
//   dma_rdata         bus read data for DMA reads
//   cpu_halt          CPU stall (RDY low equivalent)
//   dma_active        DMA owns the bus
//   dma_addr/wdata/rw DMA bus master signals (rw: 1 = read, 0 = write)
//   dma_done          one-clock pulse when a transfer completes
//   dma_count         completed transfer counter (STATS build only)
module nes_oam_dma #(
    parameter logic [15:0] TRIGGER_ADDR  = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_cycle_en,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_rw,
    input  logic [7:0]  dma_rdata,
    output logic        cpu_halt,
    output logic        dma_active,
    output logic [15:0] dma_addr,
    output logic [7:0]  dma_wdata,
    output logic        dma_rw,
    output logic        dma_done
`ifdef NES_OAM_DMA_STATS_EN
    ,
    output logic [7:0]  dma_count
`endif
);

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } state_t;

    state_t              state, state_next;
    logic                parity;
    logic [DATA_W-1:0]   page, page_next;
    logic [DATA_W-1:0]   index, index_next;
    logic [DATA_W-1:0]   index_inc;

    logic                cpu_halt_next;
    logic                dma_active_next;
    logic [ADDR_W-1:0]   dma_addr_next;
    logic [DATA_W-1:0]   dma_wdata_next;
    logic                dma_rw_next;
    logic                dma_done_next;

    // Index is 8 bits on purpose: page $FF ends at $FFFF with no carry into the page.
    assign index_inc = DATA_W'(index + DATA_W'(1));

    // State and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            parity     <= 1'b0;
            page       <= '0;
            index      <= '0;
            cpu_halt   <= 1'b0;
            dma_active <= 1'b0;
            dma_addr   <= '0;
            dma_wdata  <= '0;
            dma_rw     <= 1'b1;
            dma_done   <= 1'b0;
        end else begin
            state      <= state_next;
            parity     <= cpu_cycle_en ? ~parity : parity;
            page       <= page_next;
            index      <= index_next;
            cpu_halt   <= cpu_halt_next;
            dma_active <= dma_active_next;
            dma_addr   <= dma_addr_next;
            dma_wdata  <= dma_wdata_next;
            dma_rw     <= dma_rw_next;
            dma_done   <= dma_done_next;
        end
    end

    // Next-state and next-output logic; everything holds unless a strobe arrives
    always_comb begin
        state_next      = state;
        page_next       = page;
        index_next      = index;
        cpu_halt_next   = cpu_halt;
        dma_active_next = dma_active;
        dma_addr_next   = dma_addr;
        dma_wdata_next  = dma_wdata;
        dma_rw_next     = dma_rw;
        dma_done_next   = 1'b0;

        if (cpu_cycle_en) begin
            case (state)
                IDLE: begin
                    if (!cpu_rw && (cpu_addr == TRIGGER_ADDR)) begin
                        page_next       = cpu_wdata;
                        state_next      = HALT;
                        cpu_halt_next   = 1'b1;
                        dma_active_next = 1'b1;
                        dma_rw_next     = 1'b1;
                    end
                end
                HALT: begin
                    // parity is the HALT cycle's own; odd here means the next cycle is a get
                    if (parity) begin
                        state_next    = READ;
                        dma_addr_next = {page, index};
                    end else begin
                        state_next    = ALIGN;
                    end
                end
                ALIGN: begin
                    state_next    = READ;
                    dma_addr_next = {page, index};
                end
                READ: begin
                    dma_wdata_next = dma_rdata;
                    dma_addr_next  = OAM_DATA_ADDR;
                    dma_rw_next    = 1'b0;
                    state_next     = WRITE;
                end
                WRITE: begin
                    if (index == 8'hFF) begin
                        state_next      = IDLE;
                        index_next      = '0;
                        cpu_halt_next   = 1'b0;
                        dma_active_next = 1'b0;
                        dma_addr_next   = '0;
                        dma_wdata_next  = '0;
                        dma_rw_next     = 1'b1;
                        dma_done_next   = 1'b1;
                    end else begin
                        index_next    = index_inc;
                        dma_addr_next = {page, index_inc};
                        dma_rw_next   = 1'b1;
                        state_next    = READ;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

`ifdef NES_OAM_DMA_STATS_EN
    // Completed-transfer counter, advancing with the same edge that raises dma_done
    always_ff @(posedge clock) begin
        if (reset) begin
            dma_count <= '0;
        end else if (dma_done_next) begin
            dma_count <= DATA_W'(dma_count + DATA_W'(1));
        end
    end
`endif

endmodule

// File: tb/tb_nes_oam_dma.sv
// Testbench for nes_oam_dma: table of CPU accesses with expected transfer
// lengths, a scoreboard of expected (read address, OAM write data) pairs
// checked on every DMA put cycle, plus hand sequences for non-trigger traffic
// during a transfer and reset in the middle of a transfer.
module tb_nes_oam_dma;

    localparam logic [15:0] OAM_ADDR = 16'h2004;

    logic        clock;
    logic        reset;
    logic        cpu_cycle_en;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_rw;
    logic [7:0]  dma_rdata;
    logic        cpu_halt;
    logic        dma_active;
    logic [15:0] dma_addr;
    logic [7:0]  dma_wdata;
    logic        dma_rw;
    logic        dma_done;
`ifdef NES_OAM_DMA_STATS_EN
    logic [7:0]  dma_count;
`endif

    nes_oam_dma dut (
        .clock       (clock),
        .reset       (reset),
        .cpu_cycle_en(cpu_cycle_en),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_rw      (cpu_rw),
        .dma_rdata   (dma_rdata),
        .cpu_halt    (cpu_halt),
        .dma_active  (dma_active),
        .dma_addr    (dma_addr),
        .dma_wdata   (dma_wdata),
        .dma_rw      (dma_rw),
        .dma_done    (dma_done)
`ifdef NES_OAM_DMA_STATS_EN
        ,
        .dma_count   (dma_count)
`endif
    );

    // Memory contents: page $02 holds i ^ $A5, other pages differ by page number
    function automatic logic [7:0] memf(input logic [15:0] a);
        return a[7:0] ^ 8'hA5 ^ a[15:8] ^ 8'h02;
    endfunction

    assign dma_rdata = memf(dma_addr);

    typedef struct packed {
        logic [15:0] raddr;
        logic [7:0]  data;
    } exp_t;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        logic        rw;
        logic        par;
        logic        trig;
        int          halt_len;
    } vec_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          done_cnt = 0;
    int          halt_strobes = 0;
    int          writes = 0;
    logic        tb_par = 1'b0;
    logic [15:0] prev_addr = 16'h0;
    logic        prev_rw = 1'b1;
    logic        prev_par = 1'b0;
    int          stats_model = 0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // CPU-cycle strobe: one clock in four
    initial begin
        cpu_cycle_en = 1'b0;
        forever begin
            repeat (3) @(negedge clock);
            cpu_cycle_en = 1'b1;
            @(negedge clock);
            cpu_cycle_en = 1'b0;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: sampled mid-cycle, before the posedge that consumes the strobe
    always begin
        exp_t e;
        @(negedge clock);
        #2;
        if (dma_done) done_cnt++;
        if (reset) begin
            tb_par = 1'b0;
        end else if (cpu_cycle_en) begin
            if (cpu_halt) halt_strobes++;
            if (dma_active && !dma_rw) begin
                writes++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL extra_write: got write to %0h data %0h, expected none", dma_addr, dma_wdata);
                end else begin
                    e = exp_q.pop_front();
                    check("oam_write", 64'({dma_addr, dma_wdata, prev_addr}), 64'({OAM_ADDR, e.data, e.raddr}));
                    check("get_put_phase", 64'({prev_rw, prev_par, tb_par}), 64'({1'b1, 1'b0, 1'b1}));
                end
            end
            prev_addr = dma_addr;
            prev_rw   = dma_rw;
            prev_par  = tb_par;
            tb_par    = ~tb_par;
        end
    end

    // Return just after the posedge that consumed a strobe
    task automatic next_strobe();
        do @(posedge clock); while (!cpu_cycle_en);
        #1;
    endtask

    // One CPU bus cycle; optionally aligned so the access cycle has parity par
    task automatic cpu_access(input logic [15:0] a, input logic [7:0] d, input logic rw,
                              input logic use_par, input logic par);
        int guard = 0;
        next_strobe();
        while (use_par && (tb_par != par) && guard < 4) begin
            next_strobe();
            guard++;
        end
        cpu_addr  = a;
        cpu_wdata = d;
        cpu_rw    = rw;
        next_strobe();
        cpu_addr  = 16'h0000;
        cpu_wdata = 8'h00;
        cpu_rw    = 1'b1;
    endtask

    task automatic push_page(input logic [7:0] pg);
        exp_t e;
        for (int i = 0; i < 256; i++) begin
            e.raddr = {pg, 8'(i)};
            e.data  = memf(e.raddr);
            exp_q.push_back(e);
        end
    endtask

    // Wait (bounded) for the transfer to end, then check the idle bus
    task automatic finish_transfer(input string name, input int done_base, input int halt_base,
                                   input int halt_len);
        int n = 0;
        while (done_cnt == done_base && n < 4000) begin
            @(posedge clock);
            n++;
        end
        repeat (3) next_strobe();
        check({name, "_done_pulses"}, 64'(done_cnt - done_base), 64'd1);
        check({name, "_halt_strobes"}, 64'(halt_strobes - halt_base), 64'(halt_len));
        check({name, "_queue_left"}, 64'(exp_q.size()), 64'd0);
        check({name, "_idle_bus"}, 64'({cpu_halt, dma_active, dma_addr, dma_wdata, dma_rw}),
              64'({1'b0, 1'b0, 16'h0000, 8'h00, 1'b1}));
        exp_q.delete();
        stats_model = (stats_model + 1) % 256;
`ifdef NES_OAM_DMA_STATS_EN
        check({name, "_dma_count"}, 64'(dma_count), 64'(stats_model));
`endif
    endtask

    task automatic run_vec(input vec_t v, input int k);
        string nm;
        int done_base, halt_base, wr_base;
        nm = $sformatf("vec%0d", k);
        done_base = done_cnt;
        halt_base = halt_strobes;
        wr_base   = writes;
        if (v.trig) push_page(v.data);
        cpu_access(v.addr, v.data, v.rw, 1'b1, v.par);
        check({nm, "_halt_after_access"}, 64'({cpu_halt, dma_active}), 64'({v.trig, v.trig}));
        if (v.trig) begin
            finish_transfer(nm, done_base, halt_base, v.halt_len);
        end else begin
            repeat (10) next_strobe();
            check({nm, "_no_transfer"}, 64'({32'(halt_strobes - halt_base), 32'(writes - wr_base)}), 64'd0);
        end
    endtask

    initial begin
        vec_t vecs[8];
        int   done_base, halt_base, n;

        vecs[0] = '{16'h4014, 8'h02, 1'b0, 1'b0, 1'b1, 513};
        vecs[1] = '{16'h4014, 8'h02, 1'b0, 1'b1, 1'b1, 514};
        vecs[2] = '{16'h4015, 8'h07, 1'b0, 1'b0, 1'b0, 0};
        vecs[3] = '{16'h4014, 8'h09, 1'b1, 1'b1, 1'b0, 0};
        vecs[4] = '{16'h4014, 8'hFF, 1'b0, 1'b0, 1'b1, 513};
        vecs[5] = '{16'h4014, 8'h80, 1'b0, 1'b1, 1'b1, 514};
        vecs[6] = '{16'h2004, 8'h11, 1'b0, 1'b0, 1'b0, 0};
        vecs[7] = '{16'h4014, 8'h00, 1'b0, 1'b1, 1'b1, 514};

        reset     = 1'b1;
        cpu_addr  = 16'h0000;
        cpu_wdata = 8'h00;
        cpu_rw    = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("reset_outputs", 64'({cpu_halt, dma_active, dma_addr, dma_wdata, dma_rw, dma_done}),
              64'({1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0}));
`ifdef NES_OAM_DMA_STATS_EN
        check("reset_dma_count", 64'(dma_count), 64'd0);
`endif
        reset = 1'b0;

        for (int k = 0; k < 8; k++) run_vec(vecs[k], k);

        // Stray $4014 write and other traffic during an active transfer are ignored
        done_base = done_cnt;
        halt_base = halt_strobes;
        push_page(8'h03);
        cpu_access(16'h4014, 8'h03, 1'b0, 1'b1, 1'b0);
        repeat (5) next_strobe();
        cpu_access(16'h4014, 8'h55, 1'b0, 1'b0, 1'b0);
        cpu_access(16'h4015, 8'h66, 1'b0, 1'b0, 1'b0);
        finish_transfer("busy_trigger", done_base, halt_base, 513);
        halt_base = halt_strobes;
        repeat (10) next_strobe();
        check("busy_trigger_no_restart", 64'(halt_strobes - halt_base), 64'd0);

        // Reset at index 100 abandons the transfer without dma_done
        push_page(8'h04);
        halt_base = writes;
        cpu_access(16'h4014, 8'h04, 1'b0, 1'b1, 1'b0);
        n = 0;
        while ((writes - halt_base) < 100 && n < 4000) begin
            @(posedge clock);
            n++;
        end
        #1;
        check("reset_mid_reached_index", 64'(writes - halt_base), 64'd100);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("reset_mid_halt_drop", 64'({cpu_halt, dma_active, dma_addr, dma_rw}),
              64'({1'b0, 1'b0, 16'h0000, 1'b1}));
        exp_q.delete();
        stats_model = 0;
        done_base = done_cnt;
        halt_base = halt_strobes;
        repeat (20) next_strobe();
        check("reset_mid_no_done", 64'({32'(done_cnt - done_base), 32'(halt_strobes - halt_base)}), 64'd0);
        run_vec('{16'h4014, 8'h05, 1'b0, 1'b1, 1'b1, 514}, 8);
        run_vec('{16'h4014, 8'h06, 1'b0, 1'b0, 1'b1, 513}, 9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/nes_oam_dma.md
Name: nes_oam_dma

Overview:
- Sprite OAM DMA engine on the CPU side of the NES bus, directly downstream of the CPU core's write port.
- Snoops CPU writes to $4014. On a hit it halts the CPU and takes the bus as master.
- Copies 256 bytes from CPU page $XX00-$XXFF to the PPU OAM data port ($2004) as alternating read/write cycles.
- Timing runs on the CPU-cycle strobe produced by the /12 clock divider.

Parameters:
- TRIGGER_ADDR, 16'h4014, CPU write address that starts a DMA.
- OAM_DATA_ADDR, 16'h2004, destination address for every DMA write.

Ports:
- clock  in  1  21.47727 MHz master clock
- reset  in  1  synchronous, active-high reset
- cpu_cycle_en  in  1  one-clock strobe marking the end of each CPU cycle
- cpu_addr  in  16  CPU address bus (snooped)
- cpu_wdata  in  8  CPU write data (snooped)
- cpu_rw  in  1  CPU read/write; 1 = read, 0 = write
- dma_rdata  in  8  bus read data returned for DMA reads
- cpu_halt  out  1  stalls the CPU (RDY low equivalent) while high
- dma_active  out  1  DMA owns the bus; bus mux selects dma_* signals
- dma_addr  out  16  DMA bus address
- dma_wdata  out  8  DMA bus write data
- dma_rw  out  1  DMA read/write; 1 = read, 0 = write
- dma_done  out  1  one-clock pulse when a transfer completes
- dma_count  out  8  completed-transfer counter (only with NES_OAM_DMA_STATS_EN)

Behaviour:
- Reset (synchronous, active-high): all state is cleared, regardless of whether a transfer is in progress.
  - state=IDLE, parity=0, index=0, page=0.
  - cpu_halt=0, dma_active=0, dma_addr=0, dma_wdata=0, dma_rw=1, dma_done=0, dma_count=0.
  - Reset mid-transfer abandons the transfer: cpu_halt drops on the next clock and no dma_done is issued.
- Parity:
  - 1-bit parity register toggles on every cpu_cycle_en.
  - A cycle's parity is the register value at that cycle's strobe, before the toggle.
  - Even parity = "get" cycle; odd parity = "put" cycle.
- All state transitions and output updates happen only on clocks where cpu_cycle_en=1. Outputs hold between strobes.
- Trigger:
  - Condition: state=IDLE and cpu_cycle_en=1 and cpu_rw=0 and cpu_addr==TRIGGER_ADDR.
  - Action: latch page<=cpu_wdata, go to HALT, set cpu_halt=1 and dma_active=1.
  - Writes to any other address, reads of TRIGGER_ADDR, and triggers while not IDLE are all ignored.
- States (transitions are taken at the cpu_cycle_en that ends each cycle):
  - IDLE: bus outputs at reset values.
  - HALT: one dummy cycle; dma_rw=1. Next state is READ if the next cycle is even, else ALIGN.
  - ALIGN: one dummy cycle; dma_rw=1. Next state is READ.
  - READ (always an even cycle): dma_addr={page,index}, dma_rw=1. At the ending strobe, latch dma_wdata<=dma_rdata and go to WRITE.
  - WRITE (always an odd cycle): dma_addr=OAM_DATA_ADDR, dma_rw=0, dma_wdata held. At the ending strobe:
    - if index==255: go to IDLE, clear cpu_halt and dma_active, restore bus reset values, pulse dma_done for one clock, wrap index to 0.
    - else: index<=index+1 and go to READ.
- Latency:
  - Trigger on an even cycle: 513 halted CPU cycles (HALT + 256 READ/WRITE pairs).
  - Trigger on an odd cycle: 514 halted CPU cycles (HALT + ALIGN + 256 pairs).
- Address arithmetic: 8-bit index only, so page $FF reads $FF00-$FFFF and never carries into the page.

Optional Feature:
- Macro: NES_OAM_DMA_STATS_EN.
- Defined:
  - dma_count port exists.
  - Increments modulo 256 on each dma_done.
  - Resets to 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Even-cycle trigger: write $02 to $4014 on an even cycle, memory[$0200+i]=i^$A5 -> cpu_halt high for exactly 513 strobes; 256 writes to $2004 carrying data i^$A5 in order i=0..255; one dma_done pulse.
- Odd-cycle trigger: same write on an odd cycle -> 514 halted strobes; exactly one ALIGN cycle; every first READ falls on parity 0.
- Non-trigger traffic: write to $4015, read of $4014, and a second $4014 write during an active DMA -> no new transfer starts and page stays unchanged.
- Page wrap: page $FF -> last read address $FFFF, index wraps to 0, dma_addr returns to 0 after completion.
- Reset mid-transfer: assert reset at index=100 -> cpu_halt=0 on the next clock, no dma_done pulse; a fresh trigger then performs a full 513/514-cycle transfer.
- Stats (macro on): run 257 transfers -> dma_count=1; with the macro off, the design elaborates with no dma_count port.
